// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Owns the program counter, presents it to the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   stall            hazard-unit hold: freeze PC and IF/ID
//   redirect         taken branch/jump: load redirect_target and flush IF/ID
//   redirect_target  byte address of the redirect destination
//   imem_addr        byte address to instruction memory (equals pc)
//   imem_instr       instruction word returned by memory in the same cycle
//   if_id_instr      registered instruction for decode
//   if_id_pc         registered PC of if_id_instr
//   if_id_pc_plus4   registered if_id_pc + 4 (link value for jal/jalr)
//   if_id_valid      1 = real instruction, 0 = bubble
//   fetch_halted     1 while pc lies outside instruction memory
//   misalign_err     sticky flag, set by a redirect to a non-word address
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fetch_halted,
    output logic        misalign_err
);

    // Highest byte address at which a full word can still be fetched.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        in_range;

    always_comb begin
        in_range     = (pc <= LAST_PC);
        pc_next_seq  = pc + 32'd4;
        imem_addr    = pc;
        fetch_halted = !in_range;
    end

    // Priority: redirect > stall > normal fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= 32'd4;
            if_id_valid    <= 1'b0;
            misalign_err   <= 1'b0;
        end else if (redirect) begin
            // Flush the slot; if_id_pc/if_id_pc_plus4 deliberately hold.
            pc          <= {redirect_target[31:2], 2'b00};
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else if (!stall) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_next_seq;
            if (in_range) begin
                if_id_instr <= imem_instr;
                if_id_valid <= 1'b1;
                pc          <= pc_next_seq;
            end else begin
                // Past end of memory: keep issuing bubbles, never sample imem.
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEMB = 128;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_halted;
    logic        misalign_err;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (128),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .fetch_halted    (fetch_halted),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory; anything outside returns a poison value.
    logic [31:0] mem [32];
    assign imem_instr = (imem_addr <= 32'd124) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, updated once per rising edge.
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
    logic        m_valid, m_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = NOP; m_ipc = 0; m_ip4 = 4; m_valid = 0; m_mis = 0;
    endtask

    task automatic model_edge(input bit s, input bit r, input logic [31:0] t);
        longint unsigned next_end;
        if (r) begin
            m_pc    = t & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_valid = 0;
            if (t % 4 != 0) m_mis = 1;
        end else if (!s) begin
            m_ipc = m_pc;
            m_ip4 = m_pc + 32'd4;
            next_end = longint'(m_pc) + 4;
            if (next_end <= MEMB) begin
                m_instr = mem[m_pc / 4];
                m_valid = 1;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_instr = NOP;
                m_valid = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic halted;
        halted = (longint'(m_pc) + 4 > MEMB);
        chk({tag, ".pc"},     imem_addr,      m_pc);
        chk({tag, ".instr"},  if_id_instr,    m_instr);
        chk({tag, ".ifpc"},   if_id_pc,       m_ipc);
        chk({tag, ".ifpc4"},  if_id_pc_plus4, m_ip4);
        chk({tag, ".valid"},  32'(if_id_valid),  32'(m_valid));
        chk({tag, ".misal"},  32'(misalign_err), 32'(m_mis));
        chk({tag, ".halted"}, 32'(fetch_halted), 32'(halted));
    endtask

    // Drive inputs, take one rising edge, advance the model, sample at edge+1.
    task automatic step(input bit s, input bit r, input logic [31:0] t);
        stall = s; redirect = r; redirect_target = t;
        @(posedge clk);
        model_edge(s, r, t);
        #1;
    endtask

    typedef struct {
        bit          s;
        bit          r;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_ifpc;
        bit          e_valid;
        bit          e_mis;
    } vec_t;

    vec_t tbl[12];

    initial begin
        reset = 1; stall = 0; redirect = 0; redirect_target = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i * 4);
        mem[0] = 32'h00F0_8833;
        mem[1] = 32'h00E6_8633;
        mem[2] = 32'h0012_0423;
        model_reset();

        tbl[0]  = '{0, 0, 32'h0,  32'd4,    32'h00F0_8833, 32'd0,    1, 0};
        tbl[1]  = '{0, 0, 32'h0,  32'd8,    32'h00E6_8633, 32'd4,    1, 0};
        tbl[2]  = '{1, 0, 32'h0,  32'd8,    32'h00E6_8633, 32'd4,    1, 0};
        tbl[3]  = '{1, 0, 32'h0,  32'd8,    32'h00E6_8633, 32'd4,    1, 0};
        tbl[4]  = '{0, 0, 32'h0,  32'd12,   32'h0012_0423, 32'd8,    1, 0};
        tbl[5]  = '{0, 0, 32'h0,  32'd16,   32'hA000_000C, 32'd12,   1, 0};
        tbl[6]  = '{1, 1, 32'h20, 32'h20,   NOP,           32'd12,   0, 0};
        tbl[7]  = '{0, 0, 32'h0,  32'h24,   32'hA000_0020, 32'h20,   1, 0};
        tbl[8]  = '{0, 1, 32'h22, 32'h20,   NOP,           32'h20,   0, 1};
        tbl[9]  = '{0, 0, 32'h0,  32'h24,   32'hA000_0020, 32'h20,   1, 1};
        tbl[10] = '{0, 1, 32'h4,  32'h4,    NOP,           32'h20,   0, 1};
        tbl[11] = '{0, 0, 32'h0,  32'h8,    32'h00E6_8633, 32'h4,    1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc",    imem_addr,      32'd0);
        chk("rst.instr", if_id_instr,    NOP);
        chk("rst.ifpc",  if_id_pc,       32'd0);
        chk("rst.ifpc4", if_id_pc_plus4, 32'd4);
        chk("rst.valid", 32'(if_id_valid),  32'd0);
        chk("rst.misal", 32'(misalign_err), 32'd0);
        chk("rst.halt",  32'(fetch_halted), 32'd0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].tgt);
            chk($sformatf("tbl%0d.pc", i),    imem_addr,      tbl[i].e_pc);
            chk($sformatf("tbl%0d.instr", i), if_id_instr,    tbl[i].e_instr);
            chk($sformatf("tbl%0d.ifpc", i),  if_id_pc,       tbl[i].e_ifpc);
            chk($sformatf("tbl%0d.ifpc4", i), if_id_pc_plus4, tbl[i].e_ifpc + 32'd4);
            chk($sformatf("tbl%0d.valid", i), 32'(if_id_valid),  32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.misal", i), 32'(misalign_err), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d.halt", i),  32'(fetch_halted), 32'(tbl[i].e_pc > 32'd124));
        end

        // End of memory: run from 112 to past the last word.
        step(0, 1, 32'd112);
        check_model("eom.redir");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            check_model($sformatf("eom.f%0d", i));
        end
        chk("eom.last.instr", if_id_instr, 32'hA000_007C);
        chk("eom.last.ifpc",  if_id_pc,    32'd124);
        chk("eom.last.valid", 32'(if_id_valid),  32'd1);
        chk("eom.pc128",      imem_addr,   32'd128);
        chk("eom.halted",     32'(fetch_halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(i == 1, 0, 0);
            check_model($sformatf("eom.h%0d", i));
            chk($sformatf("eom.h%0d.nop", i),   if_id_instr, NOP);
            chk($sformatf("eom.h%0d.pc", i),    imem_addr,   32'd128);
            chk($sformatf("eom.h%0d.ifpc4", i), if_id_pc_plus4, 32'd132);
        end
        step(0, 1, 32'd0);
        check_model("eom.back");
        step(0, 0, 0);
        chk("eom.resume.instr", if_id_instr, 32'h00F0_8833);
        chk("eom.resume.valid", 32'(if_id_valid), 32'd1);
        chk("eom.misal.sticky", 32'(misalign_err), 32'd1);

        // Asynchronous reset between edges at pc=40.
        step(0, 1, 32'd40);
        chk("mid.pc40", imem_addr, 32'd40);
        #2;
        reset = 1;
        #1;
        chk("mid.pc",    imem_addr,      32'd0);
        chk("mid.instr", if_id_instr,    NOP);
        chk("mid.ifpc",  if_id_pc,       32'd0);
        chk("mid.ifpc4", if_id_pc_plus4, 32'd4);
        chk("mid.valid", 32'(if_id_valid),  32'd0);
        chk("mid.misal", 32'(misalign_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        step(0, 0, 0);
        chk("mid.restart.instr", if_id_instr, 32'h00F0_8833);
        chk("mid.restart.pc",    imem_addr,   32'd4);
        check_model("mid.restart");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic [31:0] tgt;
            bit s, r;
            sel = $urandom_range(0, 99);
            s = ($urandom_range(0, 3) == 0);
            r = (sel < 10);
            case ($urandom_range(0, 5))
                0:       tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                1:       tgt = 32'($urandom_range(120, 140));
                default: tgt = 32'($urandom_range(0, 127));
            endcase
            if (sel == 99) begin
                reset = 1;
                #1;
                model_reset();
                check_model($sformatf("rnd%0d.rst", n));
                @(posedge clk);
                #1;
                reset = 0;
            end else begin
                step(s, r, tgt);
                check_model($sformatf("rnd%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
